// File: rtl/gcn_pkg.sv
// gcn_pkg: shared constants, types and COO index decoding for the GCN aggregation stage
package gcn_pkg;
  localparam int NUM_OF_NODES = 6;
  localparam int WEIGHT_COLS = 3;
  localparam int DOT_PROD_WIDTH = 16;
  localparam int COO_NUM_OF_COLS = 6;
  localparam int COO_BW = $clog2(COO_NUM_OF_COLS);
  localparam int MAX_ADDRESS_WIDTH = 2;
  localparam int AGG_WIDTH = DOT_PROD_WIDTH + $clog2(2 * COO_NUM_OF_COLS + 1);
  typedef enum logic [1:0] {IDLE, EDGE, ARGMAX, DONE} state_t;
  typedef logic [COO_BW-1:0] node_idx_t;
  typedef logic [AGG_WIDTH-1:0] acc_t;
  typedef struct packed {
    logic valid;
    node_idx_t row;
  } coo_dec_t;
  // COO node indices are 1-based; 0 and anything past the last node are invalid
  function automatic coo_dec_t decode_idx(input node_idx_t k);
    return '{valid: k != '0 && k <= node_idx_t'(NUM_OF_NODES), row: k - 1'b1};
  endfunction
endpackage

// File: rtl/gcn_argmax_row.sv
// gcn_argmax_row: index of the largest class score in one row, lowest index on ties
module gcn_argmax_row
  import gcn_pkg::*;
(
  input  acc_t [WEIGHT_COLS-1:0]       row,
  output logic [MAX_ADDRESS_WIDTH-1:0] idx
);
  acc_t best;
  // strict compare keeps the earliest column when scores are equal
  always_comb begin
    best = row[0];
    idx = '0;
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (row[c] > best) begin
        best = row[c];
        idx = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end
endmodule

// File: rtl/gcn_aggregation_argmax.sv
// gcn_aggregation_argmax: COO edge aggregation of FM·WM rows followed by per-node argmax
module gcn_aggregation_argmax
  import gcn_pkg::*;
(
  input  logic                                                         clk,
  input  logic                                                         reset,
  input  logic                                                         fm_wm_valid,
  input  logic [NUM_OF_NODES-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_in,
  output logic                                                         in_ready,
  output logic [COO_BW-1:0]                                            coo_address,
  input  logic [2*COO_BW-1:0]                                          coo_in,
  output logic [NUM_OF_NODES-1:0][MAX_ADDRESS_WIDTH-1:0]               max_addi_answer,
  output logic                                                         done,
  output logic                                                         coo_error
);
  state_t state;
  logic [NUM_OF_NODES-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm;
  acc_t [NUM_OF_NODES-1:0][WEIGHT_COLS-1:0] acc;
  node_idx_t node;
  coo_dec_t src, dst;
  logic [MAX_ADDRESS_WIDTH-1:0] row_max;
  assign src = decode_idx(coo_in[2*COO_BW-1:COO_BW]);
  assign dst = decode_idx(coo_in[COO_BW-1:0]);
  gcn_argmax_row u_argmax (
    .row(acc[node]),
    .idx(row_max)
  );
  // capture, one edge per cycle into the accumulators, then one node argmax per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fm <= '0;
      acc <= '0;
      node <= '0;
      coo_address <= '0;
      max_addi_answer <= '0;
      done <= 1'b0;
      in_ready <= 1'b1;
      coo_error <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (fm_wm_valid) begin
            fm <= fm_wm_in;
            acc <= '0;
            coo_error <= 1'b0;
            coo_address <= '0;
            done <= 1'b0;
            in_ready <= 1'b0;
            state <= EDGE;
          end
        end
        EDGE: begin
          if (src.valid && dst.valid) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
              acc[src.row][c] <= acc[src.row][c] + acc_t'(fm[dst.row][c]);
              if (src.row != dst.row) acc[dst.row][c] <= acc[dst.row][c] + acc_t'(fm[src.row][c]);
            end
          end else begin
            coo_error <= 1'b1;
          end
          if (coo_address == COO_BW'(COO_NUM_OF_COLS - 1)) begin
            coo_address <= '0;
            node <= '0;
            state <= ARGMAX;
          end else begin
            coo_address <= coo_address + 1'b1;
          end
        end
        ARGMAX: begin
          max_addi_answer[node] <= row_max;
          if (node == node_idx_t'(NUM_OF_NODES - 1)) begin
            done <= 1'b1;
            in_ready <= 1'b1;
            state <= DONE;
          end else begin
            node <= node + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcn_aggregation_argmax.sv
// tb_gcn_aggregation_argmax: directed and randomized runs checked against an edge-list reference model
module tb_gcn_aggregation_argmax;
  import gcn_pkg::*;
  logic clk = 1'b0;
  logic reset, fm_wm_valid, in_ready, done, coo_error;
  logic [NUM_OF_NODES-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_in;
  logic [COO_BW-1:0] coo_address;
  logic [2*COO_BW-1:0] coo_in;
  logic [NUM_OF_NODES-1:0][MAX_ADDRESS_WIDTH-1:0] max_addi_answer;
  int checks = 0, errors = 0;
  int unsigned fmv [6][3];
  int es [6], ed [6];
  logic [2:0] cs [8], cd [8];
  logic [11:0] exp_ans;
  logic exp_err;

  gcn_aggregation_argmax dut (
    .clk(clk), .reset(reset), .fm_wm_valid(fm_wm_valid), .fm_wm_in(fm_wm_in),
    .in_ready(in_ready), .coo_address(coo_address), .coo_in(coo_in),
    .max_addi_answer(max_addi_answer), .done(done), .coo_error(coo_error)
  );

  always #5 clk = ~clk;
  assign coo_in = {cs[coo_address], cd[coo_address]};

  task automatic load();
    for (int n = 0; n < 6; n++)
      for (int c = 0; c < 3; c++) fm_wm_in[n][c] = fmv[n][c][15:0];
    for (int i = 0; i < 8; i++) begin
      cs[i] = i < 6 ? es[i][2:0] : 3'd0;
      cd[i] = i < 6 ? ed[i][2:0] : 3'd0;
    end
  endtask

  task automatic model();
    longint a [6][3];
    for (int n = 0; n < 6; n++)
      for (int c = 0; c < 3; c++) a[n][c] = 0;
    exp_err = 1'b0;
    for (int e = 0; e < 6; e++) begin
      int s = es[e], d = ed[e];
      if (s < 1 || s > 6 || d < 1 || d > 6) exp_err = 1'b1;
      else if (s == d) for (int c = 0; c < 3; c++) a[s-1][c] += fmv[s-1][c];
      else for (int c = 0; c < 3; c++) begin
        a[s-1][c] += fmv[d-1][c];
        a[d-1][c] += fmv[s-1][c];
      end
    end
    for (int n = 0; n < 6; n++) begin
      int best = 0;
      for (int c = 1; c < 3; c++) if (a[n][c] > a[n][best]) best = c;
      exp_ans[n*2 +: 2] = best[1:0];
    end
  endtask

  task automatic set_ring();
    es = '{1, 2, 3, 4, 5, 6};
    ed = '{2, 3, 4, 5, 6, 1};
  endtask

  task automatic set_rows(input int unsigned a, input int unsigned b, input int unsigned c);
    for (int n = 0; n < 6; n++) fmv[n] = '{a, b, c};
  endtask

  task automatic run(input string name, input int pulse_at);
    int cycles = 0;
    load();
    model();
    @(negedge clk);
    fm_wm_valid = 1'b1;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        fm_wm_valid = 1'b0;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s done_after_accept got %b want 0", name, done); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_busy got %b want 0", name, in_ready); end
      end
      if (pulse_at != 0 && cycles == pulse_at) begin
        fm_wm_valid = 1'b1;
        fm_wm_in = ~fm_wm_in;
      end else if (pulse_at != 0 && cycles == pulse_at + 1) begin
        fm_wm_valid = 1'b0;
      end
      if (done === 1'b1) break;
    end
    checks++;
    if (cycles != 13) begin errors++; $display("FAIL %s done_latency got %0d want 13", name, cycles); end
    checks++;
    if (max_addi_answer !== exp_ans) begin errors++; $display("FAIL %s answers got %h want %h", name, max_addi_answer, exp_ans); end
    checks++;
    if (coo_error !== exp_err) begin errors++; $display("FAIL %s coo_error got %b want %b", name, coo_error, exp_err); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_done got %b want 1", name, in_ready); end
    load();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    checks++;
    if (coo_address !== '0) begin errors++; $display("FAIL reset coo_address got %0d want 0", coo_address); end
    checks++;
    if (coo_error !== 1'b0) begin errors++; $display("FAIL reset coo_error got %b want 0", coo_error); end
    checks++;
    if (max_addi_answer !== '0) begin errors++; $display("FAIL reset answers got %h want 0", max_addi_answer); end
  endtask

  task automatic test_ring();
    set_rows(10, 20, 30);
    set_ring();
    run("ring", 0);
    checks++;
    if (max_addi_answer !== 12'b10_10_10_10_10_10) begin errors++; $display("FAIL ring literal got %h want aaa", max_addi_answer); end
  endtask

  task automatic test_mixed();
    set_rows(0, 1, 0);
    fmv[0] = '{100, 0, 0};
    set_ring();
    run("mixed", 0);
    checks++;
    if (max_addi_answer !== {2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1}) begin errors++; $display("FAIL mixed literal got %h want 151", max_addi_answer); end
  endtask

  task automatic test_tie_self();
    set_rows(5, 5, 5);
    es = '{1, 2, 4, 6, 1, 3};
    ed = '{1, 3, 5, 6, 2, 4};
    run("tie_self", 0);
    checks++;
    if (max_addi_answer !== '0) begin errors++; $display("FAIL tie_self literal got %h want 0", max_addi_answer); end
  endtask

  task automatic test_bad_index();
    for (int n = 0; n < 6; n++)
      for (int c = 0; c < 3; c++) fmv[n][c] = $urandom_range(0, 200);
    fmv[4] = '{0, 0, 900};
    fmv[2] = '{900, 0, 0};
    set_ring();
    es[2] = 0;
    ed[2] = 4;
    run("bad_index", 0);
    checks++;
    if (max_addi_answer[3] !== 2'd2) begin errors++; $display("FAIL bad_index node4 got %0d want 2", max_addi_answer[3]); end
    checks++;
    if (coo_error !== 1'b1) begin errors++; $display("FAIL bad_index sticky got %b want 1", coo_error); end
  endtask

  task automatic test_no_wrap();
    set_rows(16'hFFFE, 16'hFFFE, 16'hFFFF);
    es = '{1, 1, 1, 1, 1, 1};
    ed = '{2, 2, 2, 2, 2, 2};
    run("no_wrap", 0);
    checks++;
    if (max_addi_answer !== {2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2}) begin errors++; $display("FAIL no_wrap literal got %h want 00a", max_addi_answer); end
  endtask

  task automatic test_reset_mid_edge();
    set_rows(1, 9, 3);
    set_ring();
    load();
    @(negedge clk);
    fm_wm_valid = 1'b1;
    @(posedge clk);
    #1;
    fm_wm_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (coo_address !== 3'd4) begin errors++; $display("FAIL mid_edge coo_address got %0d want 4", coo_address); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || coo_address !== '0)
      begin errors++; $display("FAIL mid_edge_reset ctrl got done=%b rdy=%b addr=%0d want 0 1 0", done, in_ready, coo_address); end
    checks++;
    if (max_addi_answer !== '0) begin errors++; $display("FAIL mid_edge_reset answers got %h want 0", max_addi_answer); end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL mid_edge_idle done got %b want 0", done); end
  endtask

  task automatic test_valid_in_argmax();
    for (int n = 0; n < 6; n++)
      for (int c = 0; c < 3; c++) fmv[n][c] = $urandom_range(0, 1000);
    set_ring();
    run("valid_in_argmax", 9);
  endtask

  task automatic randomize_case(input int unsigned maxv);
    for (int n = 0; n < 6; n++)
      for (int c = 0; c < 3; c++) fmv[n][c] = $urandom_range(0, maxv);
    for (int e = 0; e < 6; e++) begin
      int v = $urandom_range(0, 15);
      int w = $urandom_range(0, 15);
      es[e] = v < 14 ? v % 6 + 1 : (v == 14 ? 0 : 7);
      ed[e] = w < 14 ? w % 6 + 1 : (w == 14 ? 0 : 7);
    end
  endtask

  task automatic test_back_to_back();
    randomize_case(65535);
    run("b2b_first", 0);
    randomize_case(3);
    run("b2b_second", 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      randomize_case(r % 2 == 0 ? 65535 : 3);
      run("random", 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    fm_wm_valid = 1'b0;
    fm_wm_in = '0;
    for (int i = 0; i < 8; i++) begin cs[i] = 3'd0; cd[i] = 3'd0; end
    test_reset();
    test_ring();
    test_mixed();
    test_tie_self();
    test_bad_index();
    test_no_wrap();
    test_reset_mid_edge();
    test_valid_in_argmax();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
